// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// A system-clock divider produces a one-clk pixel enable. Horizontal and
// vertical counters advance on that enable. Sync, active-video and the line
// and frame strobes are registered from the next-state counter values, so
// every output changes on the same clk edge as x/y.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 11,
    parameter int FW       = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          restart,
    output logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_cnt
);

    // Derived geometry
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    // Parameter sanity: the divider needs at least one clk per pixel and the
    // counters must be able to hold the largest total.
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if ((2 ** CW) <= H_TOTAL || (2 ** CW) <= V_TOTAL) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    // Registered state
    logic [DW-1:0] r_div;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [FW-1:0] r_fcnt;
    logic          r_pix_ce;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_video_on;
    logic          r_line_start;
    logic          r_frame_start;

    // Next-state values
    logic [DW-1:0] w_div_nxt;
    logic          w_tick;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [CW-1:0] w_x_nxt;
    logic [CW-1:0] w_y_nxt;
    logic [FW-1:0] w_fcnt_nxt;
    logic          w_upd;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_vid;

    // Divider: count enabled clks, tick on the last one; restart clears it
    // and suppresses the tick for that clk.
    always_comb begin
        w_tick    = 1'b0;
        w_div_nxt = r_div;
        if (restart) begin
            w_div_nxt = '0;
        end else if (enable) begin
            if (r_div == DIV_LAST) begin
                w_tick    = 1'b1;
                w_div_nxt = '0;
            end else begin
                w_div_nxt = r_div + 1'b1;
            end
        end
    end

    // Raster position: x steps per tick, y per line wrap, frame count per
    // frame wrap. Restart jumps to (0,0) but keeps the frame count.
    always_comb begin
        w_h_wrap   = w_tick && (r_x == H_LAST);
        w_v_wrap   = w_h_wrap && (r_y == V_LAST);
        w_x_nxt    = r_x;
        w_y_nxt    = r_y;
        w_fcnt_nxt = r_fcnt;
        if (restart) begin
            w_x_nxt = '0;
            w_y_nxt = '0;
        end else if (w_tick) begin
            if (w_h_wrap) begin
                w_x_nxt = '0;
                if (w_v_wrap) begin
                    w_y_nxt    = '0;
                    w_fcnt_nxt = r_fcnt + 1'b1;
                end else begin
                    w_y_nxt = r_y + 1'b1;
                end
            end else begin
                w_x_nxt = r_x + 1'b1;
            end
        end
    end

    // Region decode of the position the counters are about to take, so the
    // registered flags line up with x/y with no relative skew.
    always_comb begin
        w_upd    = restart || w_tick;
        w_hs_act = (w_x_nxt >= HS_FIRST) && (w_x_nxt <= HS_LAST);
        w_vs_act = (w_y_nxt >= VS_FIRST) && (w_y_nxt <= VS_LAST);
        w_vid    = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
    end

    // Divider and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_fcnt <= '0;
        end else begin
            r_div  <= w_div_nxt;
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_fcnt <= w_fcnt_nxt;
        end
    end

    // Output registers: strobes are single-clk; level outputs only move when
    // the position moves, so they hold while enable is low and stay at their
    // reset levels until the first pixel step or restart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_ce      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_hsync       <= ~HS_ON;
            r_vsync       <= ~VS_ON;
            r_video_on    <= 1'b0;
        end else begin
            r_pix_ce      <= w_tick;
            r_line_start  <= restart || w_h_wrap;
            r_frame_start <= restart || w_v_wrap;
            if (w_upd) begin
                r_hsync    <= w_hs_act ? HS_ON : ~HS_ON;
                r_vsync    <= w_vs_act ? VS_ON : ~VS_ON;
                r_video_on <= w_vid;
            end
        end
    end

    assign pix_ce      = r_pix_ce;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480 timing, a tiny
// CLK_DIV=1 active-high-hsync raster with FW=2, and a small CLK_DIV=3 raster
// with active-high vsync) checked against vectors and an arithmetic model.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- DUT A: default parameters ----------------
  logic en_a, rs_a;
  logic a_pix, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [10:0] a_x, a_y;
  logic [7:0] a_fc;

  vga_timing_gen u_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .restart(rs_a),
    .pix_ce(a_pix), .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  // ---------------- DUT B: tiny raster, CLK_DIV=1, HS_POL=1, FW=2 ----------------
  logic en_b, rs_b;
  logic b_pix, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [10:0] b_x, b_y;
  logic [1:0] b_fc;

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1), .VS_POL(0), .CW(11), .FW(2)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .restart(rs_b),
    .pix_ce(b_pix), .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  // ---------------- DUT C: small raster, CLK_DIV=3, VS_POL=1, FW=3 ----------------
  logic en_c, rs_c;
  logic c_pix, c_hs, c_vs, c_von, c_ls, c_fs;
  logic [10:0] c_x, c_y;
  logic [2:0] c_fc;

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(5), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HS_POL(0), .VS_POL(1), .CW(11), .FW(3)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .enable(en_c), .restart(rs_c),
    .pix_ce(c_pix), .hsync(c_hs), .vsync(c_vs), .video_on(c_von),
    .x(c_x), .y(c_y), .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int div, ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, fw;
  } geom_t;

  // e: enabled clks since reset/restart; fc_base: frame count at last restart;
  // started: a restart has happened (position is defined even at p=0);
  // l_en/l_rs: inputs seen at the most recent edge.
  typedef struct {
    int e;
    int fc_base;
    int started;
    int l_en;
    int l_rs;
  } mst_t;

  typedef struct {
    int x, y, fc, pix, hs, vs, von, ls, fs;
  } obs_t;

  localparam geom_t G_A = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 8};
  localparam geom_t G_C = '{3, 5, 2, 3, 1, 3, 1, 2, 2, 0, 1, 3};

  mst_t ms_a, ms_c;

  function automatic mst_t m_reset();
    mst_t s;
    s.e = 0; s.fc_base = 0; s.started = 0; s.l_en = 0; s.l_rs = 0;
    return s;
  endfunction

  // Outputs follow from the number of completed pixel periods p = e / div.
  function automatic obs_t model_obs(geom_t g, mst_t s);
    obs_t o;
    int ht, vt, p, live, in_hs, in_vs;
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    p = s.e / g.div;
    o.x = p % ht;
    o.y = (p / ht) % vt;
    o.fc = (s.fc_base + p / (ht * vt)) % (1 << g.fw);
    live = (s.started != 0 || p > 0) ? 1 : 0;
    in_hs = (o.x >= g.ha + g.hf && o.x < g.ha + g.hf + g.hs) ? 1 : 0;
    in_vs = (o.y >= g.va + g.vf && o.y < g.va + g.vf + g.vs) ? 1 : 0;
    o.hs = (live != 0 && in_hs != 0) ? g.hpol : 1 - g.hpol;
    o.vs = (live != 0 && in_vs != 0) ? g.vpol : 1 - g.vpol;
    o.von = (live != 0 && o.x < g.ha && o.y < g.va) ? 1 : 0;
    o.pix = (s.l_en != 0 && s.l_rs == 0 && (s.e % g.div) == 0) ? 1 : 0;
    o.ls = (s.l_rs != 0 || (o.pix != 0 && o.x == 0)) ? 1 : 0;
    o.fs = (s.l_rs != 0 || (o.pix != 0 && o.x == 0 && o.y == 0)) ? 1 : 0;
    return o;
  endfunction

  function automatic mst_t model_edge(geom_t g, mst_t s, logic en, logic rs);
    mst_t n;
    obs_t cur;
    cur = model_obs(g, s);
    n = s;
    if (rs) begin
      n.e = 0;
      n.fc_base = cur.fc;
      n.started = 1;
    end else if (en) begin
      n.e = s.e + 1;
    end
    n.l_en = en ? 1 : 0;
    n.l_rs = rs ? 1 : 0;
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input string what, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s.%s: got %0d, expected %0d", tag, what, act, exp);
  endtask

  task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
    chk(tag, "x", a.x, e.x);
    chk(tag, "y", a.y, e.y);
    chk(tag, "frame_cnt", a.fc, e.fc);
    chk(tag, "pix_ce", a.pix, e.pix);
    chk(tag, "hsync", a.hs, e.hs);
    chk(tag, "vsync", a.vs, e.vs);
    chk(tag, "video_on", a.von, e.von);
    chk(tag, "line_start", a.ls, e.ls);
    chk(tag, "frame_start", a.fs, e.fs);
  endtask

  function automatic obs_t get_a();
    obs_t o;
    o.x = int'(a_x); o.y = int'(a_y); o.fc = int'(a_fc);
    o.pix = int'(a_pix); o.hs = int'(a_hs); o.vs = int'(a_vs);
    o.von = int'(a_von); o.ls = int'(a_ls); o.fs = int'(a_fs);
    return o;
  endfunction

  function automatic obs_t get_c();
    obs_t o;
    o.x = int'(c_x); o.y = int'(c_y); o.fc = int'(c_fc);
    o.pix = int'(c_pix); o.hs = int'(c_hs); o.vs = int'(c_vs);
    o.von = int'(c_von); o.ls = int'(c_ls); o.fs = int'(c_fs);
    return o;
  endfunction

  // ---------------- driver: one clk, models follow the applied inputs ----------------
  task automatic step();
    @(posedge clk);
    ms_a = model_edge(G_A, ms_a, en_a, rs_a);
    ms_c = model_edge(G_C, ms_c, en_c, rs_c);
    @(negedge clk);
  endtask

  // ---------------- vectors for DUT B (cumulative enabled clks k) ----------------
  typedef struct {
    int k, x, y, hs, vs, von, pix, ls, fs, fc;
  } vec_t;
  vec_t vecs[17];

  // ---------------- test ----------------
  initial begin
    int cur_k;
    int found;
    int last_pix, bad_gap, hs_low, hs_first, hs_last, von_cnt, ls_cnt;

    reset_n = 1'b0;
    en_a = 1'b0; rs_a = 1'b0;
    en_b = 1'b0; rs_b = 1'b0;
    en_c = 1'b0; rs_c = 1'b0;
    ms_a = m_reset();
    ms_c = m_reset();

    //            k    x  y  hs vs von pix ls fs fc
    vecs[0]  = '{  1,  1, 0, 0, 1, 1, 1, 0, 0, 0};
    vecs[1]  = '{  9,  9, 0, 0, 1, 0, 1, 0, 0, 0};
    vecs[2]  = '{ 10, 10, 0, 1, 1, 0, 1, 0, 0, 0};
    vecs[3]  = '{ 11, 11, 0, 1, 1, 0, 1, 0, 0, 0};
    vecs[4]  = '{ 12, 12, 0, 0, 1, 0, 1, 0, 0, 0};
    vecs[5]  = '{ 14,  0, 1, 0, 1, 1, 1, 1, 0, 0};
    vecs[6]  = '{ 15,  1, 1, 0, 1, 1, 1, 0, 0, 0};
    vecs[7]  = '{ 28,  0, 2, 0, 1, 1, 1, 1, 0, 0};
    vecs[8]  = '{ 56,  0, 4, 0, 1, 0, 1, 1, 0, 0};
    vecs[9]  = '{ 70,  0, 5, 0, 0, 0, 1, 1, 0, 0};
    vecs[10] = '{ 80, 10, 5, 1, 0, 0, 1, 0, 0, 0};
    vecs[11] = '{ 84,  0, 6, 0, 1, 0, 1, 1, 0, 0};
    vecs[12] = '{ 98,  0, 0, 0, 1, 1, 1, 1, 1, 1};
    vecs[13] = '{ 99,  1, 0, 0, 1, 1, 1, 0, 0, 1};
    vecs[14] = '{196,  0, 0, 0, 1, 1, 1, 1, 1, 2};
    vecs[15] = '{294,  0, 0, 0, 1, 1, 1, 1, 1, 3};
    vecs[16] = '{392,  0, 0, 0, 1, 1, 1, 1, 1, 0};

    // Reset state on all instances.
    @(negedge clk);
    step();
    cmp_obs("rst_a", get_a(), '{0, 0, 0, 0, 1, 1, 0, 0, 0});
    chk("rst_b", "hsync", int'(b_hs), 0);
    chk("rst_b", "vsync", int'(b_vs), 1);
    chk("rst_c", "hsync", int'(c_hs), 1);
    chk("rst_c", "vsync", int'(c_vs), 0);
    reset_n = 1'b1;

    // Idle with enable low: nothing moves, video_on stays low.
    for (int i = 0; i < 3; i++) begin
      step();
      cmp_obs("idle_a", get_a(), model_obs(G_A, ms_a));
    end

    // Table: DUT B, one pixel per clk.
    en_b = 1'b1;
    cur_k = 0;
    for (int i = 0; i < 17; i++) begin
      while (cur_k < vecs[i].k) begin
        step();
        cur_k++;
      end
      chk($sformatf("vec%0d", i), "x", int'(b_x), vecs[i].x);
      chk($sformatf("vec%0d", i), "y", int'(b_y), vecs[i].y);
      chk($sformatf("vec%0d", i), "hsync", int'(b_hs), vecs[i].hs);
      chk($sformatf("vec%0d", i), "vsync", int'(b_vs), vecs[i].vs);
      chk($sformatf("vec%0d", i), "video_on", int'(b_von), vecs[i].von);
      chk($sformatf("vec%0d", i), "pix_ce", int'(b_pix), vecs[i].pix);
      chk($sformatf("vec%0d", i), "line_start", int'(b_ls), vecs[i].ls);
      chk($sformatf("vec%0d", i), "frame_start", int'(b_fs), vecs[i].fs);
      chk($sformatf("vec%0d", i), "frame_cnt", int'(b_fc), vecs[i].fc);
    end

    // DUT A line sweep up to (x=100, y=1), gathering line-0 statistics.
    en_a = 1'b1;
    found = 0; last_pix = -1; bad_gap = 0;
    hs_low = 0; hs_first = -1; hs_last = -1; von_cnt = 0; ls_cnt = 0;
    for (int cyc = 1; cyc <= 10000; cyc++) begin
      step();
      cmp_obs("sweep_a", get_a(), model_obs(G_A, ms_a));
      if (a_ls) ls_cnt++;
      if (a_pix) begin
        if (last_pix >= 0 && cyc - last_pix != 4) bad_gap++;
        last_pix = cyc;
        if (a_y == 11'd0) begin
          if (!a_hs) begin
            hs_low++;
            if (hs_first < 0) hs_first = int'(a_x);
            hs_last = int'(a_x);
          end
          if (a_von) von_cnt++;
        end
        if (a_x == 11'd100 && a_y == 11'd1) begin
          found = 1;
          break;
        end
      end
    end
    chk("sweep_a", "reached", found, 1);
    chk("sweep_a", "pix_gap_errors", bad_gap, 0);
    chk("sweep_a", "hsync_low_pixels", hs_low, 96);
    chk("sweep_a", "hsync_first_x", hs_first, 656);
    chk("sweep_a", "hsync_last_x", hs_last, 751);
    // x=0 of line 0 is never sampled on a pix_ce, leaving x=1..639 visible.
    chk("sweep_a", "video_on_pixels", von_cnt, 639);
    chk("sweep_a", "line_starts", ls_cnt, 1);

    // Enable drop with the divider part-way through a pixel.
    step();
    step();
    chk("hold_a", "x_before", int'(a_x), 100);
    en_a = 1'b0;
    for (int i = 0; i < 37; i++) begin
      step();
      chk("hold_a", "x", int'(a_x), 100);
      chk("hold_a", "pix_ce", int'(a_pix), 0);
      chk("hold_a", "line_start", int'(a_ls), 0);
    end
    en_a = 1'b1;
    step();
    chk("resume_a", "x_1", int'(a_x), 100);
    chk("resume_a", "pix_1", int'(a_pix), 0);
    step();
    chk("resume_a", "x_2", int'(a_x), 101);
    chk("resume_a", "pix_2", int'(a_pix), 1);
    cmp_obs("resume_a", get_a(), model_obs(G_A, ms_a));

    // Restart from inside the hsync pulse.
    found = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      cmp_obs("pre_rs_a", get_a(), model_obs(G_A, ms_a));
      if (a_pix && a_x == 11'd700) begin
        found = 1;
        break;
      end
    end
    chk("pre_rs_a", "reached", found, 1);
    chk("pre_rs_a", "hsync", int'(a_hs), 0);
    rs_a = 1'b1;
    step();
    rs_a = 1'b0;
    chk("restart_a", "x", int'(a_x), 0);
    chk("restart_a", "y", int'(a_y), 0);
    chk("restart_a", "video_on", int'(a_von), 1);
    chk("restart_a", "hsync", int'(a_hs), 1);
    chk("restart_a", "vsync", int'(a_vs), 1);
    chk("restart_a", "frame_start", int'(a_fs), 1);
    chk("restart_a", "pix_ce", int'(a_pix), 0);
    chk("restart_a", "frame_cnt", int'(a_fc), 0);
    cmp_obs("restart_a", get_a(), model_obs(G_A, ms_a));

    // Asynchronous reset between clk edges while pix_ce is high.
    found = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      if (a_pix && a_x == 11'd20) begin
        found = 1;
        break;
      end
    end
    chk("arst_a", "reached", found, 1);
    chk("arst_a", "video_on_before", int'(a_von), 1);
    #2;
    reset_n = 1'b0;
    #1;
    cmp_obs("arst_a", get_a(), '{0, 0, 0, 0, 1, 1, 0, 0, 0});
    chk("arst_b", "x", int'(b_x), 0);
    chk("arst_b", "frame_cnt", int'(b_fc), 0);
    chk("arst_b", "hsync", int'(b_hs), 0);
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    ms_a = m_reset();
    ms_c = m_reset();
    step();
    reset_n = 1'b1;

    // Restart right after reset, then randomized enable/restart on A and C.
    rs_a = 1'b1;
    step();
    rs_a = 1'b0;
    cmp_obs("post_rst_a", get_a(), model_obs(G_A, ms_a));
    for (int i = 0; i < 3000; i++) begin
      en_a = ($urandom_range(0, 7) != 0);
      rs_a = ($urandom_range(0, 499) == 0);
      en_c = ($urandom_range(0, 9) != 0);
      rs_c = ($urandom_range(0, 149) == 0);
      step();
      cmp_obs("rand_a", get_a(), model_obs(G_A, ms_a));
      cmp_obs("rand_c", get_c(), model_obs(G_C, ms_c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
